// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and word-memory bus bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store unit over a 32-bit word memory (optional LSU_BOUNDS_CHECK_EN)
module lsu_mem_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          oob_q, oob_d;

    logic          illegal, misaligned, fault;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   merge_data;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob_d = (state_q == IDLE) ? (|bus.req_addr[31:AW+2]) : oob_q;
`else
    assign oob_d = 1'b0;
`endif

    always_comb begin
        illegal    = bus.req_we ? 1'b0 : 1'b0;
        illegal    = we_q ? (funct3_q >= 3'd3)
                          : (funct3_q == 3'd3 || funct3_q == 3'd6 || funct3_q == 3'd7);
        misaligned = (funct3_q[1:0] == 2'b01 && addr_q[0])
                  || (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    end
    assign fault = illegal || misaligned || oob_q;

    always_comb begin
        byte_sel = bus.mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
        load_val = 32'd0;
        case (funct3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd2:    load_val = bus.mem_rd_data;
            3'd4:    load_val = {24'd0, byte_sel};
            3'd5:    load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    // Sub-word stores merge into the word read back in the same ACCESS cycle.
    always_comb begin
        merge_data = bus.mem_rd_data;
        case (funct3_q[1:0])
            2'b00:   merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merge_data = wdata_q;
        endcase
    end

    assign bus.mem_addr    = addr_q[AW+1:2];
    assign bus.mem_wr_data = merge_data;
    assign bus.mem_wr_en   = (state_q == ACCESS) && we_q && !fault && !rst;
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[AW+1:0];
                    wdata_d  = bus.req_wdata;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (fault || we_q) ? 32'd0 : load_val;
                err_d   = fault;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            oob_q    <= oob_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed vector bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.AW(8)) bus ();
    lsu_mem_ctrl #(.DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_data = 32'd0;
    int          wr_count = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    assign bus.mem_rd_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            n_chk = n_chk + 1;
            if (bus.mem_wr_en !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL wr_en_in_reset: got %b required 0", bus.mem_wr_en);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int wrs);
        int w0;
        w0 = wr_count;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        wrs = wr_count - w0;
    endtask

    typedef struct {
        string       name;
        logic        pre;
        logic [7:0]  pre_word;
        logic [31:0] pre_data;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wr;
        logic [7:0]  chk_word;
        logic [31:0] chk_data;
    } vec_t;

    vec_t vecs [21];

    initial begin
        logic [31:0] rd, snap;
        logic        er;
        int          lat, wrs, w0;
        bit          bchk;

`ifdef LSU_BOUNDS_CHECK_EN
        bchk = 1'b1;
`else
        bchk = 1'b0;
`endif
        vecs[0]  = '{"sw_10",      0, 0, 0,            1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1, 4, 32'hDEADBEEF};
        vecs[1]  = '{"lw_10",      0, 0, 0,            0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 0, 0, 4, 32'hDEADBEEF};
        vecs[2]  = '{"sb_11",      0, 0, 0,            1, 3'd0, 32'h11,  32'hFFFFFF55, 32'h0,        0, 1, 4, 32'hDEAD55EF};
        vecs[3]  = '{"lb_11",      0, 0, 0,            0, 3'd0, 32'h11,  32'h0,        32'h00000055, 0, 0, 4, 32'hDEAD55EF};
        vecs[4]  = '{"lbu_13",     0, 0, 0,            0, 3'd4, 32'h13,  32'h0,        32'h000000DE, 0, 0, 4, 32'hDEAD55EF};
        vecs[5]  = '{"lb_10_neg",  0, 0, 0,            0, 3'd0, 32'h10,  32'h0,        32'hFFFFFFEF, 0, 0, 4, 32'hDEAD55EF};
        vecs[6]  = '{"lh_12",      1, 4, 32'h8001FFFF, 0, 3'd1, 32'h12,  32'h0,        32'hFFFF8001, 0, 0, 4, 32'h8001FFFF};
        vecs[7]  = '{"lhu_12",     0, 0, 0,            0, 3'd5, 32'h12,  32'h0,        32'h00008001, 0, 0, 4, 32'h8001FFFF};
        vecs[8]  = '{"lh_10",      0, 0, 0,            0, 3'd1, 32'h10,  32'h0,        32'hFFFFFFFF, 0, 0, 4, 32'h8001FFFF};
        vecs[9]  = '{"lhu_10",     0, 0, 0,            0, 3'd5, 32'h10,  32'h0,        32'h0000FFFF, 0, 0, 4, 32'h8001FFFF};
        vecs[10] = '{"sh_12",      0, 0, 0,            1, 3'd1, 32'h12,  32'h1234ABCD, 32'h0,        0, 1, 4, 32'hABCDFFFF};
        vecs[11] = '{"sw_13_mis",  0, 0, 0,            1, 3'd2, 32'h13,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[12] = '{"lh_01_mis",  0, 0, 0,            0, 3'd1, 32'h01,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[13] = '{"ld_f3_3",    0, 0, 0,            0, 3'd3, 32'h10,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[14] = '{"ld_f3_6",    0, 0, 0,            0, 3'd6, 32'h10,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[15] = '{"st_f3_3",    0, 0, 0,            1, 3'd3, 32'h10,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[16] = '{"lw_11_mis",  0, 0, 0,            0, 3'd2, 32'h11,  32'h0,        32'h0,        1, 0, 4, 32'hABCDFFFF};
        vecs[17] = '{"sb_07",      1, 1, 32'h11223344, 1, 3'd0, 32'h07,  32'h000000AB, 32'h0,        0, 1, 1, 32'hAB223344};
        vecs[18] = '{"lbu_06",     0, 0, 0,            0, 3'd4, 32'h06,  32'h0,        32'h00000022, 0, 0, 1, 32'hAB223344};
        if (bchk) begin
            vecs[19] = '{"sw_400_oob", 1, 0, 32'h11111111, 1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0, 1, 0, 0, 32'h11111111};
            vecs[20] = '{"lw_400_oob", 0, 0, 0,            0, 3'd2, 32'h400, 32'h0,        32'h0, 1, 0, 0, 32'h11111111};
        end else begin
            vecs[19] = '{"sw_400_wrap", 1, 0, 32'h11111111, 1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0,        0, 1, 0, 32'hCAFEF00D};
            vecs[20] = '{"lw_400_wrap", 0, 0, 0,            0, 3'd2, 32'h400, 32'h0,        32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D};
        end

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err",   {31'd0, bus.resp_err}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].pre) preload(vecs[i].pre_word, vecs[i].pre_data);
            run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, wrs);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},   {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_lat"},   lat, 32'd2);
            chk({vecs[i].name, "_writes"}, wrs, vecs[i].exp_wr);
            chk({vecs[i].name, "_mem"},   mem[vecs[i].chk_word], vecs[i].chk_data);
        end

        // Response held under backpressure.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_resp_rdata", bus.resp_rdata, 32'hABCDFFFF);
            chk("bp_req_ready",  {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);

        // Reset during ACCESS of a store.
        preload(8'd5, 32'h0);
        w0 = wr_count;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h14; bus.req_wdata = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rstacc_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstacc_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        chk("rstacc_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstacc_writes", wr_count - w0, 32'd0);
        chk("rstacc_mem", mem[5], 32'h0);

        // Reset during RESP drops the response.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstresp_pre_valid", {31'd0, bus.resp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstresp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstresp_rdata", bus.resp_rdata, 32'd0);
        chk("rstresp_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
